ltpi_csr_avmm_bank: RTL and testbench
=====================================

// Module: ltpi_csr_avmm_bank
// PURPOSE
//  Parametrised Avalon-MM CSR register bank; successor to the fixed LTPI CSR AVMM block.
//  Configurable register count, data width, read latency and per-register type (RW/RO/W1C).
//  Sits between the LTPI management AVMM fabric and the LTPI link/ctrl logic.
//  Exposes register contents, write strobes and hardware status-set inputs.
// PARAMETERS
//  DATA_W    32            register and bus data width; multiple of 8
//  NUM_REGS  16            number of word registers; 2..256
//  ADDR_W    8             word address width; 2**ADDR_W >= NUM_REGS
//  RD_LAT    1             read latency from accepted read to readdatavalid; 1..3
//  RO_MASK   '0            NUM_REGS bits; 1 = read-only, value taken from hw_ro_data
//  W1C_MASK  '0            NUM_REGS bits; 1 = status, hw-set / write-1-to-clear (RO wins if both set)
//  RST_VAL   '0            NUM_REGS*DATA_W reset image for RW registers
// PORTS
//  clk                 in   1                  single clock
//  reset               in   1                  synchronous, active-high
//  avmm_address        in   ADDR_W             word address
//  avmm_read           in   1                  read request
//  avmm_write          in   1                  write request
//  avmm_writedata      in   DATA_W             write data
//  avmm_byteenable     in   DATA_W/8           byte lanes
//  avmm_waitrequest    out  1                  1 = command not accepted
//  avmm_readdata       out  DATA_W             read data
//  avmm_readdatavalid  out  1                  read data valid
//  avmm_response       out  2                  2'b00 OKAY, 2'b10 SLVERR (with readdatavalid)
//  hw_set              in   NUM_REGS*DATA_W    per-bit set for W1C registers
//  hw_ro_data          in   NUM_REGS*DATA_W    live values for RO registers
//  reg_q               out  NUM_REGS*DATA_W    current register contents
//  reg_wr_pulse        out  NUM_REGS           1-cycle strobe, register written this cycle
// BEHAVIOUR
//  - Reset: RW regs = RST_VAL slice, W1C regs = 0; readdatavalid=0, readdata=0, response=0,
//    reg_wr_pulse=0; waitrequest=1 during reset and the first cycle after release, then 0.
//  - Command accepted when (read|write) && !waitrequest; one command per cycle, fully pipelined.
//  - Write: per byte lane b with byteenable[b]: RW reg <= writedata; W1C reg bits with 1 cleared;
//    RO reg unchanged. Update visible on reg_q the cycle after acceptance; reg_wr_pulse same cycle.
//  - W1C precedence: hw_set bit and write-1-clear of the same bit in the same cycle -> bit ends 1.
//  - Read: data sampled at acceptance (RO from hw_ro_data that cycle), returned exactly RD_LAT
//    cycles later with readdatavalid=1 for one cycle; back-to-back reads return in order.
//  - Address >= NUM_REGS: write dropped, no strobe; read returns readdata=32'hDEAD_C5R0-free
//    pattern ERR_DATA (package const) with response=SLVERR; in-range response=OKAY.
//  - read && write same cycle: protocol error; write performed, read dropped, no readdatavalid.
//  - Write then read same address in next cycle: read returns the newly written value.
//  - Reset mid-flight: in-pipe reads discarded, no readdatavalid emitted after reset asserts.
//  - readdata holds last value when readdatavalid=0.
// CONFIGURATION
//  LTPI_CSR_COR_EN defined: accepted in-range read of a W1C register also clears the bits returned,
//    except bits whose hw_set is 1 in the acceptance cycle (those remain 1).
//  Not defined: reads are side-effect free; W1C cleared only by write-1.
// STRUCTURE
//  ltpi_csr_pkg: avmm_resp_t enum (OKAY/SLVERR), ERR_DATA = 'hBAD0_CAFE, reg_type_t (RW/RO/W1C),
//    function reg_type(idx, RO_MASK, W1C_MASK).
//  Sub-module ltpi_csr_rd_pipe: RD_LAT-deep valid/data/response shift register with sync clear.
// TESTING
//  1 Reset release: waitrequest 1 for reset+1 cycle; read reg0 with RST_VAL=0x11 -> 0x11 OKAY after RD_LAT.
//  2 Write reg2=0xA5A5_5A5A be=4'b0101 over 0 -> reg_q[2]=0x00A5_005A, reg_wr_pulse[2] one cycle.
//  3 W1C reg3: hw_set 0xF pulse -> 0xF; write 0x3 with hw_set 0x1 same cycle -> 0xD.
//  4 Read addr NUM_REGS (16) -> readdata 0xBAD0_CAFE, response 2'b10; write there -> no strobe, no change.
//  5 RD_LAT=3, 4 back-to-back reads regs 0..3 -> 4 consecutive readdatavalid in order; reset mid-burst -> none after.
//  6 COR_EN: reg3=0xF, read -> 0xF returned, reg3=0 next cycle; without macro reg3 stays 0xF.

Source files
------------

// File: rtl/ltpi_csr_pkg.sv
// Shared types and constants for the LTPI CSR Avalon-MM register bank.
package ltpi_csr_pkg;

    localparam int MAX_REGS = 256;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } avmm_resp_t;

    // Returned for reads that fall outside the implemented register range.
    localparam logic [31:0] ERR_DATA = 32'hBAD0_CAFE;

    typedef enum logic [1:0] {
        REG_RW  = 2'd0,
        REG_RO  = 2'd1,
        REG_W1C = 2'd2
    } reg_type_t;

    // Read-only takes precedence over W1C when both mask bits are set.
    function automatic reg_type_t reg_type(input int idx,
                                           input logic [MAX_REGS-1:0] ro_mask,
                                           input logic [MAX_REGS-1:0] w1c_mask);
        reg_type_t t;
        if (ro_mask[idx]) begin
            t = REG_RO;
        end else if (w1c_mask[idx]) begin
            t = REG_W1C;
        end else begin
            t = REG_RW;
        end
        return t;
    endfunction

endpackage

// File: rtl/ltpi_csr_avmm_bank_if.sv
// Avalon-MM slave bus bundle for the LTPI CSR register bank.
interface ltpi_csr_avmm_bank_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   avmm_address;
    logic                avmm_read;
    logic                avmm_write;
    logic [DATA_W-1:0]   avmm_writedata;
    logic [DATA_W/8-1:0] avmm_byteenable;
    logic                avmm_waitrequest;
    logic [DATA_W-1:0]   avmm_readdata;
    logic                avmm_readdatavalid;
    logic [1:0]          avmm_response;

    modport master (
        output avmm_address, avmm_read, avmm_write, avmm_writedata, avmm_byteenable,
        input  avmm_waitrequest, avmm_readdata, avmm_readdatavalid, avmm_response
    );

    modport slave (
        input  avmm_address, avmm_read, avmm_write, avmm_writedata, avmm_byteenable,
        output avmm_waitrequest, avmm_readdata, avmm_readdatavalid, avmm_response
    );
endinterface

// File: rtl/ltpi_csr_rd_pipe.sv
// Fixed-latency read return pipe: valid/data/response shift register with synchronous clear.
module ltpi_csr_rd_pipe
    import ltpi_csr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  avmm_resp_t        in_resp,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output avmm_resp_t        out_resp
);

    logic [RD_LAT-1:0] valid_r;
    logic [DATA_W-1:0] data_r [RD_LAT];
    avmm_resp_t        resp_r [RD_LAT];

    // Data/response stages only load on a valid beat so the last stage holds its value when idle.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int k = 0; k < RD_LAT; k++) begin
                valid_r[k] <= 1'b0;
                data_r[k]  <= '0;
                resp_r[k]  <= RESP_OKAY;
            end
        end else begin
            valid_r[0] <= in_valid;
            if (in_valid) begin
                data_r[0] <= in_data;
                resp_r[0] <= in_resp;
            end
            for (int k = 1; k < RD_LAT; k++) begin
                valid_r[k] <= valid_r[k-1];
                if (valid_r[k-1]) begin
                    data_r[k] <= data_r[k-1];
                    resp_r[k] <= resp_r[k-1];
                end
            end
        end
    end

    assign out_valid = valid_r[RD_LAT-1];
    assign out_data  = data_r[RD_LAT-1];
    assign out_resp  = resp_r[RD_LAT-1];

endmodule

// File: rtl/ltpi_csr_avmm_bank.sv
// Parametrised Avalon-MM CSR bank with RW / RO / W1C registers.
// Optional build macro LTPI_CSR_COR_EN: reads of W1C registers clear the returned bits.
module ltpi_csr_avmm_bank
    import ltpi_csr_pkg::*;
#(
    parameter int                         DATA_W   = 32,
    parameter int                         NUM_REGS = 16,
    parameter int                         ADDR_W   = 8,
    parameter int                         RD_LAT   = 1,
    parameter logic [NUM_REGS-1:0]        RO_MASK  = '0,
    parameter logic [NUM_REGS-1:0]        W1C_MASK = '0,
    parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL  = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    ltpi_csr_avmm_bank_if.slave          avmm,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_set,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_ro_data,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          reg_wr_pulse
);

    localparam int              BE_W       = DATA_W / 8;
    localparam logic [ADDR_W:0] NUM_REGS_A = (ADDR_W + 1)'(NUM_REGS);

    logic                       wait_r;
    logic                       wr_acc_s;
    logic                       rd_acc_s;
    logic                       in_range_s;
    logic [DATA_W-1:0]          be_mask_s;
    logic [DATA_W-1:0]          wmask_s;
    logic [NUM_REGS-1:0]        addr_hit_s;
    logic [NUM_REGS*DATA_W-1:0] rd_src_s;
    logic [DATA_W-1:0]          rd_raw_s;
    logic [DATA_W-1:0]          rd_data_s;
    avmm_resp_t                 rd_resp_s;
    avmm_resp_t                 pipe_resp_s;
    logic                       unused_s;

    // Hold off the master during reset and for one cycle after it releases.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_r <= 1'b1;
        end else begin
            wait_r <= 1'b0;
        end
    end

    // A simultaneous read+write is a protocol error: the write wins, the read is dropped.
    assign wr_acc_s   = avmm.avmm_write && !wait_r;
    assign rd_acc_s   = avmm.avmm_read && !avmm.avmm_write && !wait_r;
    assign in_range_s = ({1'b0, avmm.avmm_address} < NUM_REGS_A);
    assign wmask_s    = avmm.avmm_writedata & be_mask_s;

    // Expand byte enables into a bit mask.
    always_comb begin
        be_mask_s = '0;
        for (int b = 0; b < BE_W; b++) begin
            be_mask_s[b*8 +: 8] = {8{avmm.avmm_byteenable[b]}};
        end
    end

    // One-hot address decode and read-data selection.
    always_comb begin
        addr_hit_s = '0;
        rd_raw_s   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            addr_hit_s[i] = (avmm.avmm_address == ADDR_W'(i));
            rd_raw_s      = rd_raw_s | ({DATA_W{addr_hit_s[i]}} & rd_src_s[i*DATA_W +: DATA_W]);
        end
    end

    // Out-of-range reads return the error pattern with SLVERR.
    always_comb begin
        if (in_range_s) begin
            rd_data_s = rd_raw_s;
            rd_resp_s = RESP_OKAY;
        end else begin
            rd_data_s = DATA_W'(ERR_DATA);
            rd_resp_s = RESP_SLVERR;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        localparam reg_type_t RT = reg_type(i, MAX_REGS'(RO_MASK), MAX_REGS'(W1C_MASK));
        logic [DATA_W-1:0] q_r;
        logic              wr_hit_s;

        assign wr_hit_s = wr_acc_s && addr_hit_s[i];

        if (RT == REG_RO) begin : g_ro
            // Mirror the live hardware value so reg_q tracks it.
            always_ff @(posedge clk) begin
                if (reset) begin
                    q_r <= '0;
                end else begin
                    q_r <= hw_ro_data[i*DATA_W +: DATA_W];
                end
            end
            assign rd_src_s[i*DATA_W +: DATA_W] = hw_ro_data[i*DATA_W +: DATA_W];
        end else if (RT == REG_W1C) begin : g_w1c
            logic [DATA_W-1:0] clr_s;
`ifdef LTPI_CSR_COR_EN
            logic              rd_hit_s;
            assign rd_hit_s = rd_acc_s && addr_hit_s[i];
`endif
            // Bits to clear this cycle: write-1 lanes, plus returned bits on a clearing read.
            always_comb begin
                clr_s = wr_hit_s ? wmask_s : '0;
`ifdef LTPI_CSR_COR_EN
                clr_s = clr_s | (rd_hit_s ? q_r : '0);
`endif
            end
            // Hardware set is applied after the clear so a coincident set always wins.
            always_ff @(posedge clk) begin
                if (reset) begin
                    q_r <= '0;
                end else begin
                    q_r <= (q_r & ~clr_s) | hw_set[i*DATA_W +: DATA_W];
                end
            end
            assign rd_src_s[i*DATA_W +: DATA_W] = q_r;
        end else begin : g_rw
            // Byte-lane merge of write data into the stored value.
            always_ff @(posedge clk) begin
                if (reset) begin
                    q_r <= RST_VAL[i*DATA_W +: DATA_W];
                end else if (wr_hit_s) begin
                    q_r <= (q_r & ~be_mask_s) | wmask_s;
                end
            end
            assign rd_src_s[i*DATA_W +: DATA_W] = q_r;
        end

        assign reg_q[i*DATA_W +: DATA_W] = q_r;
    end

    // Write strobe for the addressed register, one cycle, aligned with the reg_q update.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_wr_pulse <= '0;
        end else if (wr_acc_s) begin
            reg_wr_pulse <= addr_hit_s;
        end else begin
            reg_wr_pulse <= '0;
        end
    end

    ltpi_csr_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .clr       (reset),
        .in_valid  (rd_acc_s),
        .in_data   (rd_data_s),
        .in_resp   (rd_resp_s),
        .out_valid (avmm.avmm_readdatavalid),
        .out_data  (avmm.avmm_readdata),
        .out_resp  (pipe_resp_s)
    );

    assign avmm.avmm_response    = pipe_resp_s;
    assign avmm.avmm_waitrequest = wait_r;

    // Slices of hw_set / hw_ro_data belonging to other register types are intentionally ignored.
    assign unused_s = ^{hw_set, hw_ro_data};

endmodule

// File: tb/tb_ltpi_csr_avmm_bank.sv
// Directed table-driven bench for ltpi_csr_avmm_bank (16 regs, RD_LAT=3, reg3 W1C, reg5 RO).
module tb_ltpi_csr_avmm_bank;
    import ltpi_csr_pkg::*;

    localparam int DW = 32;
    localparam int NR = 16;
    localparam int AW = 8;
    localparam int RL = 3;
`ifdef LTPI_CSR_COR_EN
    localparam bit COR = 1'b1;
`else
    localparam bit COR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [NR*DW-1:0] hw_set;
    logic [NR*DW-1:0] hw_ro_data;
    logic [NR*DW-1:0] reg_q;
    logic [NR-1:0]    reg_wr_pulse;
    int               checks = 0;
    int               errors = 0;

    always #5 clk = ~clk;

    ltpi_csr_avmm_bank_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ltpi_csr_avmm_bank #(
        .DATA_W   (DW),
        .NUM_REGS (NR),
        .ADDR_W   (AW),
        .RD_LAT   (RL),
        .RO_MASK  (16'h0020),
        .W1C_MASK (16'h0008),
        .RST_VAL  (512'h11)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .avmm         (bus.slave),
        .hw_set       (hw_set),
        .hw_ro_data   (hw_ro_data),
        .reg_q        (reg_q),
        .reg_wr_pulse (reg_wr_pulse)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] set3;
        int          chk;
        logic [31:0] exp_q;
        logic [15:0] exp_pulse;
        logic [31:0] exp_rd;
        logic [1:0]  exp_rsp;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic wr, input logic rd, input logic [7:0] addr,
                                input logic [31:0] wd, input logic [3:0] be, input logic [31:0] set3,
                                input int chk, input logic [31:0] exp_q, input logic [15:0] exp_pulse,
                                input logic [31:0] exp_rd, input logic [1:0] exp_rsp);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = addr; v.wd = wd; v.be = be; v.set3 = set3;
        v.chk = chk; v.exp_q = exp_q; v.exp_pulse = exp_pulse; v.exp_rd = exp_rd; v.exp_rsp = exp_rsp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] q(input int i);
        return reg_q[i*DW +: DW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.avmm_read       = 1'b0;
        bus.avmm_write      = 1'b0;
        bus.avmm_address    = 8'd0;
        bus.avmm_writedata  = 32'd0;
        bus.avmm_byteenable = 4'd0;
        hw_set              = '0;
    endtask

    task automatic drive_rd(input logic [7:0] a);
        idle();
        bus.avmm_read    = 1'b1;
        bus.avmm_address = a;
    endtask

    task automatic apply(input vec_t v, input int n);
        logic exp_v;
        bus.avmm_write      = v.wr;
        bus.avmm_read       = v.rd;
        bus.avmm_address    = v.addr;
        bus.avmm_writedata  = v.wd;
        bus.avmm_byteenable = v.be;
        hw_set              = '0;
        hw_set[3*DW +: DW]  = v.set3;
        step();
        idle();
        check($sformatf("v%0d_pulse", n), 32'(reg_wr_pulse), 32'(v.exp_pulse));
        check($sformatf("v%0d_regq", n), q(v.chk), v.exp_q);
        for (int k = 1; k <= RL + 1; k++) begin
            if (k > 1) step();
            exp_v = v.rd && !v.wr && (k == RL);
            check($sformatf("v%0d_rdv_k%0d", n, k), 32'(bus.avmm_readdatavalid), 32'(exp_v));
            if (exp_v || (v.rd && !v.wr && k == RL + 1)) begin
                check($sformatf("v%0d_rdata_k%0d", n, k), bus.avmm_readdata, v.exp_rd);
            end
            if (exp_v) begin
                check($sformatf("v%0d_resp", n), 32'(bus.avmm_response), 32'(v.exp_rsp));
            end
        end
    endtask

    initial begin
        logic [31:0] r3;
        logic [31:0] b2b_exp [4];

        r3 = COR ? 32'h0 : 32'hD;
        vecs[0]  = mk(1'b0, 1'b1, 8'd0,  32'h0,         4'h0, 32'h0, 0, 32'h11,        16'h0,    32'h11,        2'b00);
        vecs[1]  = mk(1'b1, 1'b0, 8'd2,  32'hA5A5_5A5A, 4'h5, 32'h0, 2, 32'h00A5_005A, 16'h0004, 32'h0,         2'b00);
        vecs[2]  = mk(1'b0, 1'b1, 8'd2,  32'h0,         4'h0, 32'h0, 2, 32'h00A5_005A, 16'h0,    32'h00A5_005A, 2'b00);
        vecs[3]  = mk(1'b0, 1'b0, 8'd0,  32'h0,         4'h0, 32'hF, 3, 32'hF,         16'h0,    32'h0,         2'b00);
        vecs[4]  = mk(1'b1, 1'b0, 8'd3,  32'h3,         4'hF, 32'h1, 3, 32'hD,         16'h0008, 32'h0,         2'b00);
        vecs[5]  = mk(1'b0, 1'b1, 8'd3,  32'h0,         4'h0, 32'h0, 3, r3,            16'h0,    32'hD,         2'b00);
        vecs[6]  = mk(1'b0, 1'b1, 8'd16, 32'h0,         4'h0, 32'h0, 0, 32'h11,        16'h0,    32'hBAD0_CAFE, 2'b10);
        vecs[7]  = mk(1'b1, 1'b0, 8'd16, 32'hFFFF_FFFF, 4'hF, 32'h0, 2, 32'h00A5_005A, 16'h0,    32'h0,         2'b00);
        vecs[8]  = mk(1'b1, 1'b0, 8'd5,  32'h0,         4'hF, 32'h0, 5, 32'h1234_5678, 16'h0020, 32'h0,         2'b00);
        vecs[9]  = mk(1'b0, 1'b1, 8'd5,  32'h0,         4'h0, 32'h0, 5, 32'h1234_5678, 16'h0,    32'h1234_5678, 2'b00);
        vecs[10] = mk(1'b1, 1'b0, 8'd1,  32'hDEAD_BEEF, 4'h8, 32'h0, 1, 32'hDE00_0000, 16'h0002, 32'h0,         2'b00);
        vecs[11] = mk(1'b1, 1'b1, 8'd4,  32'h0000_4444, 4'hF, 32'h0, 4, 32'h0000_4444, 16'h0010, 32'h0,         2'b00);

        idle();
        hw_ro_data             = '0;
        hw_ro_data[5*DW +: DW] = 32'h1234_5678;
        reset                  = 1'b1;
        repeat (3) step();
        check("rst_wait",  32'(bus.avmm_waitrequest), 32'd1);
        check("rst_rdv",   32'(bus.avmm_readdatavalid), 32'd0);
        check("rst_rdata", bus.avmm_readdata, 32'd0);
        check("rst_resp",  32'(bus.avmm_response), 32'd0);
        check("rst_pulse", 32'(reg_wr_pulse), 32'd0);
        check("rst_reg0",  q(0), 32'h11);
        check("rst_reg3",  q(3), 32'h0);
        reset = 1'b0;
        #2;
        check("wait_first_cycle", 32'(bus.avmm_waitrequest), 32'd1);
        step();
        check("wait_released", 32'(bus.avmm_waitrequest), 32'd0);

        for (int n = 0; n < 12; n++) begin
            apply(vecs[n], n);
        end

        // Write followed immediately by a read of the same register.
        bus.avmm_write      = 1'b1;
        bus.avmm_address    = 8'd6;
        bus.avmm_writedata  = 32'hCAFE_0001;
        bus.avmm_byteenable = 4'hF;
        step();
        drive_rd(8'd6);
        step();
        idle();
        step();
        step();
        check("wr_rd_rdv",   32'(bus.avmm_readdatavalid), 32'd1);
        check("wr_rd_rdata", bus.avmm_readdata, 32'hCAFE_0001);

        // Four back-to-back reads return in order on consecutive cycles.
        b2b_exp[0] = 32'h11;
        b2b_exp[1] = 32'hDE00_0000;
        b2b_exp[2] = 32'h00A5_005A;
        b2b_exp[3] = r3;
        step();
        for (int c = 0; c < 8; c++) begin
            if (c < 4) drive_rd(8'(c));
            else idle();
            step();
            check($sformatf("b2b_rdv_c%0d", c), 32'(bus.avmm_readdatavalid), 32'(c >= 2 && c <= 5));
            if (c >= 2 && c <= 5) begin
                check($sformatf("b2b_rdata_c%0d", c), bus.avmm_readdata, b2b_exp[c-2]);
            end
        end

        // Reset while reads are in flight: nothing comes out afterwards.
        drive_rd(8'd0);
        step();
        drive_rd(8'd1);
        step();
        idle();
        reset = 1'b1;
        step();
        check("midrst_rdv",   32'(bus.avmm_readdatavalid), 32'd0);
        check("midrst_rdata", bus.avmm_readdata, 32'd0);
        check("midrst_wait",  32'(bus.avmm_waitrequest), 32'd1);
        step();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("midrst_rdv_c%0d", c), 32'(bus.avmm_readdatavalid), 32'd0);
        end
        check("midrst_reg0", q(0), 32'h11);

        // Status read: clear-on-read only when the option is built in.
        hw_set[3*DW +: DW] = 32'hF;
        step();
        idle();
        check("cor_set", q(3), 32'hF);
        drive_rd(8'd3);
        step();
        idle();
        check("cor_after_read", q(3), COR ? 32'h0 : 32'hF);
        step();
        step();
        check("cor_rdv",   32'(bus.avmm_readdatavalid), 32'd1);
        check("cor_rdata", bus.avmm_readdata, 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
